// File: rtl/int_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// int_ctrl -- programmable interrupt controller
//
// Collects raw interrupt requests from the peripherals (timer IRQs, external
// interrupt, ...), latches and masks them, resolves a fixed priority (index 0
// is highest) and drives a registered one-hot request vector to the CPU. At
// most one request reaches CP0 at a time.
//
// Register window (word offsets from BASE_ADDR, all reset to 0):
//   +0x0 MASK  RW    1 = source enabled
//   +0x4 PEND  R/W1C pending bits; writing 1 clears an edge-mode bit
//   +0x8 MODE  RW    1 = rising-edge triggered, 0 = level
//   +0xC ID    R     {valid[31], INSV[15:8] (nested build only), id[2:0]}
//                    In the nested build a write here is an EOI for Din[2:0].
//
// Optional feature macro: INTC_NESTED_EOI_EN
//   Defined   -> in-service register INSV; only strictly higher-priority
//                requests than the lowest in-service index reach HWInt.
//   Undefined -> no INSV, writes to +0xC are ignored, ID[15:8] reads 0.
//
// Ports:
//   clk      in   1      system clock
//   reset    in   1      synchronous active-high reset
//   Addr     in   30     bridge word address [31:2]
//   WE       in   1      write strobe, already qualified by the block select
//   Din      in   32     write data
//   Dout     out  32     combinational read data (0 outside the window)
//   irq_src  in   N_SRC  raw interrupt requests
//   HWInt    out  N_SRC  registered one-hot (or zero) request to the CPU
// -----------------------------------------------------------------------------
module int_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f20,
  parameter int          N_SRC     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] irq_src,
  output logic [N_SRC-1:0] HWInt
);

  // Word offsets inside the 16-byte window.
  typedef enum logic [1:0] {
    REG_MASK = 2'd0,
    REG_PEND = 2'd1,
    REG_MODE = 2'd2,
    REG_ID   = 2'd3
  } reg_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] hwint_q, hwint_d;
`ifdef INTC_NESTED_EOI_EN
  logic [N_SRC-1:0] insv_q, insv_d;
`endif

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic             in_win;
  reg_e             reg_sel;
  logic             wr_mask, wr_pend, wr_mode, wr_id;
  logic [N_SRC-1:0] din_src;
  logic             unused_din;

  // The window is 16 bytes aligned on BASE_ADDR, so only Addr[3:2] selects
  // the register once the upper bits match.
  assign in_win  = (Addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel = reg_e'(Addr[3:2]);

  assign wr_mask = WE && in_win && (reg_sel == REG_MASK);
  assign wr_pend = WE && in_win && (reg_sel == REG_PEND);
  assign wr_mode = WE && in_win && (reg_sel == REG_MODE);
  assign wr_id   = WE && in_win && (reg_sel == REG_ID);

  // Bits above the implemented sources are ignored on write.
  assign din_src    = Din[N_SRC-1:0];
  assign unused_din = ^Din[31:N_SRC];

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  assign mask_d = wr_mask ? din_src : mask_q;
  assign mode_d = wr_mode ? din_src : mode_q;

  // ---------------------------------------------------------------------------
  // Pending logic
  //   edge bits : set on a rising edge, cleared by W1C; a set in the same
  //               cycle as a W1C wins.
  //   level bits: follow the raw request every cycle; W1C has no effect.
  // The current mode_q decides the rule, so a MODE write changes behaviour
  // from the cycle after the write edge. On a 0->1 change the level value
  // captured last becomes the retained edge-mode value.
  // ---------------------------------------------------------------------------
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;

  assign rise   = irq_src & ~src_q;
  assign w1c    = wr_pend ? din_src : '0;
  assign pend_d = (mode_q & (rise | (pend_q & ~w1c))) | (~mode_q & irq_src);

  // ---------------------------------------------------------------------------
  // Priority resolution
  // ---------------------------------------------------------------------------
  logic [N_SRC-1:0] req;
  int               prio_lim;   // only indices below this may be granted
  logic             found;

  assign req = pend_q & mask_q;

`ifdef INTC_NESTED_EOI_EN
  // The lowest set in-service index bounds which requests may nest on top.
  always_comb begin
    prio_lim = N_SRC;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (insv_q[i]) prio_lim = i;
    end
  end
`else
  assign prio_lim = N_SRC;
`endif

  // NOTE: every signal assigned in this always_comb gets a default at the top;
  // without it the paths that skip an assignment would infer a latch.
  always_comb begin
    hwint_d = '0;
    found   = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!found && req[i] && (i < prio_lim)) begin
        hwint_d[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

`ifdef INTC_NESTED_EOI_EN
  // EOI clears the addressed in-service bit; a newly granted source enters
  // service on the same edge that it appears on HWInt. A granted index is
  // always strictly above the in-service ones, so the two never collide.
  always_comb begin
    insv_d = insv_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (wr_id && (Din[2:0] == 3'(i))) insv_d[i] = 1'b0;
    end
    insv_d = insv_d | hwint_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q  <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      src_q   <= '0;
      hwint_q <= '0;
`ifdef INTC_NESTED_EOI_EN
      insv_q  <= '0;
`endif
    end else begin
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      src_q   <= irq_src;
      hwint_q <= hwint_d;
`ifdef INTC_NESTED_EOI_EN
      insv_q  <= insv_d;
`endif
    end
  end

  assign HWInt = hwint_q;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] onehot_idx(input logic [N_SRC-1:0] v);
    onehot_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (v[i]) onehot_idx = 3'(i);
    end
  endfunction

  always_comb begin
    Dout = '0;
    if (in_win) begin
      unique case (reg_sel)
        REG_MASK: Dout[N_SRC-1:0] = mask_q;
        REG_PEND: Dout[N_SRC-1:0] = pend_q;
        REG_MODE: Dout[N_SRC-1:0] = mode_q;
        REG_ID: begin
          Dout[31]  = |hwint_q;
          Dout[2:0] = onehot_idx(hwint_q);
`ifdef INTC_NESTED_EOI_EN
          Dout[8 +: N_SRC] = insv_q;
`endif
        end
        default: Dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_int_ctrl -- self-checking bench for int_ctrl
//
// Inputs are driven at the falling clock edge. Expected HWInt values are
// pushed into a scoreboard together with the rising edge after which they
// must hold; a monitor pops and compares them 1 ns after each rising edge.
// Register reads are compared directly at the falling edge.
// Build with +define+INTC_NESTED_EOI_EN to run the in-service sequence
// instead of the flat-priority sequences.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_7f20;
  localparam int          N_SRC = 6;

  localparam logic [31:0] A_MASK = BASE + 32'h0;
  localparam logic [31:0] A_PEND = BASE + 32'h4;
  localparam logic [31:0] A_MODE = BASE + 32'h8;
  localparam logic [31:0] A_ID   = BASE + 32'hC;

  logic             clk;
  logic             reset;
  logic [31:2]      Addr;
  logic             WE;
  logic [31:0]      Din;
  logic [31:0]      Dout;
  logic [N_SRC-1:0] irq_src;
  logic [N_SRC-1:0] HWInt;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;   // number of rising edges seen by the monitor
  int sb_id   = 0;

  typedef struct {
    int               due;
    int               id;
    logic [N_SRC-1:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];

  int_ctrl #(
    .BASE_ADDR(BASE),
    .N_SRC    (N_SRC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .Addr   (Addr),
    .WE     (WE),
    .Din    (Din),
    .Dout   (Dout),
    .irq_src(irq_src),
    .HWInt  (HWInt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expect HWInt == e after the k-th rising edge from now.
  task automatic hw(input int k, input logic [N_SRC-1:0] e);
    sb_entry_t ent;
    ent.due = cyc + k;
    ent.id  = sb_id;
    ent.exp = e;
    sb_id++;
    sb.push_back(ent);
  endtask

  // Scoreboard monitor.
  initial begin
    sb_entry_t ent;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        ent = sb.pop_front();
        check($sformatf("hw%0d@%0d", ent.id, ent.due), 32'(HWInt), 32'(ent.exp));
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_addr(input logic [31:0] a);
    Addr = a[31:2];
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    set_addr(a);
    Din = d;
    WE  = 1'b1;
    nxt();
    WE  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    WE = 1'b0;
    set_addr(a);
    #1;
    check(tag, Dout, exp);
  endtask

  initial begin
    reset   = 1'b1;
    WE      = 1'b0;
    Din     = '0;
    irq_src = '0;
    set_addr(BASE);
    repeat (3) nxt();
    reset = 1'b0;

    // Reset state.
    check("rst_hw", 32'(HWInt), 32'h0);
    rd_chk("rst_mask", A_MASK, 32'h0);
    rd_chk("rst_pend", A_PEND, 32'h0);
    rd_chk("rst_mode", A_MODE, 32'h0);
    rd_chk("rst_id",   A_ID,   32'h0);

`ifdef INTC_NESTED_EOI_EN
    // Nested: source 2 in service blocks 3, source 1 nests, EOIs release.
    wr(A_MASK, 32'h3f);
    irq_src = 6'h04; hw(1, 6'h00); hw(2, 6'h04); hw(3, 6'h00);
    nxt(); nxt(); nxt();
    rd_chk("n_id_insv2", A_ID, 32'h0000_0400);
    irq_src = 6'h0c; hw(1, 6'h00); hw(2, 6'h00);
    nxt(); nxt();
    irq_src = 6'h0e; hw(1, 6'h00); hw(2, 6'h02); hw(3, 6'h00);
    nxt(); nxt();
    rd_chk("n_id_nest", A_ID, 32'h8000_0601);
    nxt();
    hw(1, 6'h00);
    wr(A_ID, 32'h2);
    rd_chk("n_eoi2", A_ID, 32'h0000_0200);
    irq_src = 6'h0c; hw(1, 6'h00); hw(2, 6'h04);
    wr(A_ID, 32'h1);
    nxt();
    rd_chk("n_id_src2", A_ID, 32'h8000_0402);
    irq_src = '0;
`else
    // 1: single edge source, pend then HWInt, W1C clears.
    wr(A_MASK, 32'h01);
    wr(A_MODE, 32'h01);
    irq_src = 6'h01; hw(1, 6'h00); hw(2, 6'h01);
    nxt();
    irq_src = 6'h00;
    rd_chk("t1_pend", A_PEND, 32'h01);
    nxt();
    rd_chk("t1_id", A_ID, 32'h8000_0000);
    hw(1, 6'h01); hw(2, 6'h00);
    wr(A_PEND, 32'h01);
    nxt();
    rd_chk("t1_pend_clr", A_PEND, 32'h0);

    // 2: level sources, simultaneous requests, priority, W1C ignored on level.
    wr(A_MASK, 32'h3f);
    wr(A_MODE, 32'h00);
    irq_src = 6'h06; hw(1, 6'h00); hw(2, 6'h02);
    nxt(); nxt();
    rd_chk("t2_id_1", A_ID, 32'h8000_0001);
    irq_src = 6'h04; hw(1, 6'h02); hw(2, 6'h04);
    nxt(); nxt();
    rd_chk("t2_id_2", A_ID, 32'h8000_0002);
    hw(1, 6'h04); hw(2, 6'h04);
    wr(A_PEND, 32'h04);
    rd_chk("t2_lvl_w1c", A_PEND, 32'h04);
    irq_src = 6'h00; hw(2, 6'h00);
    nxt(); nxt();

    // 3: pending while masked, unmask, re-mask retains PEND.
    wr(A_MASK, 32'h00);
    wr(A_MODE, 32'h01);
    irq_src = 6'h01; hw(1, 6'h00); hw(2, 6'h00); hw(3, 6'h00);
    nxt();
    irq_src = 6'h00;
    nxt();
    rd_chk("t3_pend_masked", A_PEND, 32'h01);
    hw(2, 6'h01);
    wr(A_MASK, 32'h01);
    hw(2, 6'h00);
    wr(A_MASK, 32'h00);
    rd_chk("t3_pend_kept", A_PEND, 32'h01);
    hw(2, 6'h01);
    wr(A_MASK, 32'h01);
    hw(2, 6'h00);
    wr(A_PEND, 32'h01);
    nxt();

    // 4: W1C on the same edge as a new rising edge -> set wins.
    wr(A_MODE, 32'h3f);
    wr(A_MASK, 32'h3f);
    irq_src = 6'h04; hw(1, 6'h00); hw(2, 6'h04);
    nxt();
    irq_src = 6'h00;
    nxt();
    irq_src = 6'h04; hw(1, 6'h04);
    wr(A_PEND, 32'h04);
    rd_chk("t4_set_wins", A_PEND, 32'h04);

    // 5: reset while HWInt=04, source held high through reset.
    reset = 1'b1; hw(1, 6'h00);
    nxt();
    reset = 1'b0;
    rd_chk("t5_mask", A_MASK, 32'h0);
    rd_chk("t5_pend", A_PEND, 32'h0);
    rd_chk("t5_mode", A_MODE, 32'h0);
    rd_chk("t5_id",   A_ID,   32'h0);
    hw(1, 6'h00);
    nxt();
    rd_chk("t5_pend_lvl", A_PEND, 32'h04);
    irq_src = 6'h00;

    // Window boundaries and ignored upper write bits.
    wr(A_MASK, 32'hffff_ffff);
    rd_chk("win_mask_bits", A_MASK, 32'h3f);
    rd_chk("win_above", BASE + 32'h10, 32'h0);
    rd_chk("win_below", BASE - 32'h4, 32'h0);
`endif

    repeat (4) nxt();
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
